// File: rtl/fir_sample_seq.sv
// Sample sequencer feeding the FIR input ROM: start/stop, one-shot or loop addressing with a
// programmable stride and ROM latency compensation. Optional sample counter: FIR_SEQ_SAMPLE_CNT_EN.
module fir_sample_seq #(
   parameter int ADDR_W    = 9,
   parameter int LAST_ADDR = 501,
   parameter int ROM_LAT   = 1,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [3:0]        stride,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              done,
   output logic [7:0]        wrap_cnt,
   output logic [15:0]       sample_cnt
);

   localparam int SUM_W = ADDR_W + 4;
   localparam logic [SUM_W-1:0] LAST_EXT = SUM_W'(LAST_ADDR);
   localparam logic [SUM_W-1:0] SPAN_EXT = SUM_W'(LAST_ADDR + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t             state_reg;
   logic [ADDR_W-1:0]  address_reg;
   logic [3:0]         stride_reg;
   logic               loop_reg;
   logic               busy_reg;
   logic               done_reg;
   logic [7:0]         wrap_cnt_reg;
   logic [ROM_LAT-1:0] req_pipe_reg;
   logic [DATA_W-1:0]  sample_reg;
   logic               sample_valid_reg;

   logic               req;
   logic [SUM_W-1:0]   sum_next;
   logic               over_last;
   logic               pipe_empty;

   // stop suppresses the address presented in the same clock
   assign req        = (state_reg == RUN) && !stop;
   assign sum_next   = SUM_W'(address_reg) + SUM_W'(stride_reg);
   assign over_last  = (sum_next > LAST_EXT);
   assign pipe_empty = (req_pipe_reg == '0);

   // Request delay line matching the ROM read latency (ROM_LAT legal range 1..4)
   generate
      for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_req_pipe
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rest) begin
               if (!rest) begin
                  req_pipe_reg[gi] <= 1'b0;
               end else begin
                  req_pipe_reg[gi] <= req;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge rest) begin
               if (!rest) begin
                  req_pipe_reg[gi] <= 1'b0;
               end else begin
                  req_pipe_reg[gi] <= req_pipe_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         sample_reg       <= '0;
         sample_valid_reg <= 1'b0;
      end else begin
         sample_valid_reg <= req_pipe_reg[ROM_LAT-1];
         if (req_pipe_reg[ROM_LAT-1]) begin
            sample_reg <= rom_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_reg    <= IDLE;
         address_reg  <= '0;
         stride_reg   <= 4'd1;
         loop_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         wrap_cnt_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               address_reg <= '0;
               if (start) begin
                  state_reg    <= RUN;
                  busy_reg     <= 1'b1;
                  loop_reg     <= loop_mode;
                  stride_reg   <= (stride == 4'd0) ? 4'd1 : stride;
                  wrap_cnt_reg <= '0;
               end
            end
            RUN: begin
               if (stop) begin
                  state_reg <= DRAIN;
               end else if (over_last) begin
                  if (loop_reg) begin
                     address_reg <= ADDR_W'(sum_next - SPAN_EXT);
                     if (wrap_cnt_reg != 8'hFF) begin
                        wrap_cnt_reg <= wrap_cnt_reg + 8'd1;
                     end
                  end else begin
                     state_reg <= DRAIN;
                  end
               end else begin
                  address_reg <= ADDR_W'(sum_next);
               end
            end
            DRAIN: begin
               // empty pipe means the final sample_valid is being shown this clock
               if (pipe_empty) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg   <= IDLE;
               address_reg <= '0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef FIR_SEQ_SAMPLE_CNT_EN
   logic [15:0] sample_cnt_reg;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         sample_cnt_reg <= '0;
      end else if ((state_reg == IDLE) && start) begin
         sample_cnt_reg <= '0;
      end else if (req_pipe_reg[ROM_LAT-1] && (sample_cnt_reg != 16'hFFFF)) begin
         sample_cnt_reg <= sample_cnt_reg + 16'd1;
      end
   end

   assign sample_cnt = sample_cnt_reg;
`else
   assign sample_cnt = 16'd0;
`endif

   assign address      = address_reg;
   assign sample       = sample_reg;
   assign sample_valid = sample_valid_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign wrap_cnt     = wrap_cnt_reg;

endmodule

// File: doc/fir_sample_seq.md
Name: fir_sample_seq

Overview:
Parametrised sample sequencer that drives the FIR input ROM. It replaces the free-running address counter with a controlled block offering start/stop, one-shot or loop mode, a programmable address stride and a configurable ROM latency. It sits between the coefficient/sample ROM and fir_top. It delivers a registered sample stream with a valid strobe, plus done and wrap status.

Parameters:
ADDR_W, 9, ROM address width.
LAST_ADDR, 501, highest valid ROM address; the address space is 0..LAST_ADDR.
ROM_LAT, 1, ROM read latency in clocks (legal 1..4).
DATA_W, 16, ROM sample width.

Ports:
clk  in  1  system clock, all logic on rising edge.
rest  in  1  asynchronous active-low reset.
start  in  1  begin a sequence; honoured only in IDLE.
stop  in  1  abort the sequence; honoured only in RUN.
loop_mode  in  1  1 = wrap and continue, 0 = one-shot; latched at start.
stride  in  4  address increment; latched at start; value 0 is treated as 1.
address  out  ADDR_W  ROM read address.
rom_data  in  DATA_W  ROM output, valid ROM_LAT clocks after address.
sample  out  DATA_W  registered sample.
sample_valid  out  1  sample qualifier, one clock per sample.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-clock pulse at end of sequence.
wrap_cnt  out  8  count of wraps since start, saturates at 255.
sample_cnt  out  16  valid samples since start (optional feature).

Behaviour:
- Reset (rest=0, asynchronous): state=IDLE; address, sample, wrap_cnt, sample_cnt = 0; sample_valid, busy, done = 0; the request pipeline is cleared. In-flight samples are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - address held at 0.
  - start=1 -> RUN. On this transition: latch loop_mode and stride, and clear wrap_cnt and sample_cnt.
  - stop is ignored.
- RUN:
  - Each clock, the current address is issued (internal req=1).
  - First issued address is 0, in the first RUN clock.
  - Next address = address+stride (computed in ADDR_W+4 bits).
  - If address+stride > LAST_ADDR:
    - loop mode: address = address+stride-(LAST_ADDR+1); wrap_cnt+1, saturating.
    - one-shot: the current address is the last one issued; go to DRAIN.
  - stop=1: the address presented that clock is NOT issued; go to DRAIN.
  - stop has priority over wrap and end detection in the same clock.
- DRAIN:
  - No requests issued; address holds.
  - Stay until the request pipeline is empty and the last sample_valid has been output, then go to DONE.
- DONE: done=1 for exactly one clock, busy=0, then IDLE.
  - done asserts in the clock immediately after the final sample_valid.
  - With no samples pending, done asserts the clock after DRAIN is entered.
- Data path:
  - req is delayed by a ROM_LAT-stage shift register.
  - On the last stage, sample<=rom_data and sample_valid<=1.
  - Latency from an address being issued to its sample_valid is ROM_LAT+1 clocks.
  - sample holds its value when sample_valid=0.
- busy = (state==RUN or DRAIN).
- start while busy is ignored. start in the DONE clock is ignored.
- wrap_cnt and sample_cnt hold after done until the next start.

Optional Feature:
FIR_SEQ_SAMPLE_CNT_EN:
- Defined: sample_cnt increments on every sample_valid, saturating at 65535, and clears on accepted start and on reset.
- Undefined: the counter logic is omitted and sample_cnt is tied to 0; the port is present in both builds.

Test Plan:
1. One-shot, stride=1, ROM_LAT=1, rom_data=address.
   - 502 sample_valid pulses, values 0..501 in order.
   - First valid 2 clocks after the first RUN clock.
   - done pulse 1 clock after the value-501 sample; wrap_cnt=0; sample_cnt=502 with FIR_SEQ_SAMPLE_CNT_EN.
2. Loop mode, stride=4.
   - Addresses 0,4,...,500, then 2, 6, ...
   - wrap_cnt=1 at the first wrap.
   - Stop after 300 issued addresses -> exactly 300 valids, then done; busy=0 afterwards.
3. One-shot, stride=3, ROM_LAT=3.
   - 168 samples, last value 501.
   - Issue-to-valid latency of 4 clocks on each sample.
   - stride=0 run equals the stride=1 result.
4. Reset mid-RUN at address 100 (rest=0 for 1 clock).
   - Immediately address=0, sample_valid=0, busy=0, state IDLE.
   - No further valids; a new start replays from address 0.
5. start pulsed during RUN/DRAIN/DONE and stop pulsed in IDLE -> no effect.
   - Simultaneous start+stop in IDLE enters RUN.
6. Loop mode, stride=15, run 600000 clocks -> wrap_cnt saturates at 255.
